simd_buffer_arbiter: RTL and testbench
======================================

# simd_buffer_arbiter

Round-robin arbiter that shares one single-entry staging buffer between `N_REQ` requesters, for example SIMD lanes issuing results toward a common writeback or execution port. Each cycle the buffer is empty, it grants at most one valid, unmasked requester and captures that requester's data together with its index. The consumer drains the entry with a valid/pop handshake.

## Interface
- `N_REQ`, default 4: number of requesters; must be ≥ 2.
- `WIDTH`, default 32: payload width in bits.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester index; derived, not overridden.

- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester request.
- `req_data`  in  N_REQ×WIDTH  per-requester payload.
- `req_ready`  out  N_REQ  one-hot (or zero) acceptance strobe.
- `cfg_mask`  in  N_REQ  1 = requester enabled; 0 = never granted.
- `out_valid`  out  1  buffer holds an entry.
- `out_pop`  in  1  consumer takes the entry.
- `out_data`  out  WIDTH  buffered payload.
- `out_id`  out  ID_W  index of the requester that produced `out_data`.

## Operation
- **Eligibility.** `elig[i] = req_valid[i] & cfg_mask[i]`.
- **Grant selection.**
  - Grant is combinational.
  - Scan starts at `rr_ptr` and proceeds upward, wrapping from `N_REQ-1` to 0.
  - The first eligible index wins. This also holds for non-power-of-two `N_REQ`.
- **Ready.** `req_ready[g] = buf_ready & any(elig)`; all other `req_ready` bits are 0.
  - `req_ready` depends combinationally on other requesters' `req_valid`.
  - A requester must not make `req_valid` depend on its own `req_ready`.
- **Transfer.**
  - A transfer occurs when `req_valid[g] & req_ready[g]`.
  - The buffer captures `{g, req_data[g]}`.
  - `rr_ptr <= (g == N_REQ-1) ? 0 : g+1`.
- **Pointer hold.** `rr_ptr` is unchanged on any cycle with no transfer.
- **Buffer rules.**
  - `buf_ready = ~full`. Push is possible only when the buffer is empty.
  - Pop clears `full`. A pop while empty is ignored.
  - Push and pop cannot coincide, because push requires empty.
- **Mask changes.**
  - `cfg_mask` may change on any cycle and affects only future grants.
  - An already-buffered entry is not affected.
- **Idle and fully masked cases.** If all requesters are idle or masked, nothing is granted and `rr_ptr` holds.

## Timing
- **Reset values** (after `rst` is asserted at an edge):
  - `full = 0`, so `out_valid = 0` and `buf_ready = 1`.
  - `rr_ptr = 0`.
  - `req_ready` is 0 unless some requester is eligible.
- **Undefined outputs.** `out_data` and `out_id` are undefined until the first push. They are not reset.
- **Latency.** A transfer at edge T gives `out_valid = 1` from T+1, with `out_data`/`out_id` stable until popped.
- **Drain.** A pop at edge T gives `out_valid = 0` and `req_ready` re-enabled from T+1. The next transfer can occur at edge T+1.
- **Throughput.** Peak is one transfer every 2 cycles.
- **Reset mid-operation.**
  - A buffered entry is discarded.
  - A transfer coinciding with `rst` is dropped.
  - `rr_ptr` returns to 0.
- **Fairness.** With all `N_REQ` requesters continuously eligible, each is granted exactly once per `N_REQ` transfers.

## Structure
- **Shared package `simd_arb_pkg`:**
  - `function automatic` `rr_next(ptr, n)` for wrap increment.
  - Localparam-style helper for `ID_W`.
- **Sub-module.** Reuse the existing single-entry `buffer` module, instantiated with `WIDTH = WIDTH + ID_W`.
  - Its `push` is driven by `|(req_valid & req_ready)`.
  - Its `pop` is driven by `out_pop`.
- **Local logic.** Round-robin pointer register and grant logic (rotate, priority-encode, un-rotate) live in this module.

## Test plan
- **Reset.** `rst` for 2 cycles with all `req_valid = 1` → during reset no state change; after release `out_valid = 0`, first grant goes to index 0.
- **Single requester.** Only `req_valid[2] = 1`, data `0xA5A5_0002` → `req_ready = 4'b0100`. Next cycle `out_valid = 1`, `out_id = 2`, `out_data = 0xA5A5_0002`. `req_ready = 0` until `out_pop`.
- **Full contention.** All 4 valid, consumer pops every cycle `out_valid` is 1 → `out_id` sequence 0,1,2,3,0,1…, one transfer per 2 cycles.
- **Mask.** `cfg_mask = 4'b1010`, all valid → grants alternate 1,3,1,3. Clearing bit 3 mid-stream → only 1 is granted thereafter.
- **Backpressure and reset.**
  - Entry buffered, `out_pop = 0` for 5 cycles → `out_valid` held, `out_data` stable, `req_ready = 0`.
  - Then assert `rst` → `out_valid = 0` next cycle and `rr_ptr = 0`.
- **Spurious pop.** `out_pop = 1` while `out_valid = 0`, plus `N_REQ = 3` wrap → no state change; pointer wraps 2→0.

Source files
------------

// File: rtl/simd_arb_pkg.sv
// Shared helpers for the round-robin buffer arbiter: index width and
// wrap-around pointer increment for any requester count.
package simd_arb_pkg;

    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr >= n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/buffer.sv
// Single-entry staging buffer with valid/pop drain; the payload register
// is deliberately left unreset since it is only meaningful while full.
module buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] in_data,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] out_data
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Push only lands when empty, so push and pop never act together.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (!full_q) begin
            if (push) begin
                full_d = 1'b1;
                data_d = in_data;
            end
        end else if (pop) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign ready    = ~full_q;
    assign valid    = full_q;
    assign out_data = data_q;

endmodule

// File: rtl/simd_buffer_arbiter.sv
// Round-robin arbiter feeding N_REQ requesters into one shared single-entry
// buffer; the captured entry carries the winning requester's index.
module simd_buffer_arbiter
    import simd_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 32,
    localparam int ID_W  = id_width(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0][WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0]            cfg_mask,
    output logic                        out_valid,
    input  logic                        out_pop,
    output logic [WIDTH-1:0]            out_data,
    output logic [ID_W-1:0]             out_id
);

    logic [N_REQ-1:0]     elig;
    logic [2*N_REQ-1:0]   elig_rot2;
    logic [N_REQ-1:0]     elig_rot;
    logic                 grant_valid;
    logic [ID_W-1:0]      grant_off;
    logic [ID_W:0]        grant_sum;
    logic [ID_W-1:0]      grant_idx;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                 buf_ready;
    logic                 push;
    logic [WIDTH+ID_W-1:0] buf_in;
    logic [WIDTH+ID_W-1:0] buf_out;

    assign elig = req_valid & cfg_mask;

    // Rotate so rr_ptr sits at bit 0, take the lowest set bit, then add the
    // pointer back with an explicit wrap so non-power-of-two counts work.
    always_comb begin
        elig_rot2   = {elig, elig} >> rr_ptr_q;
        elig_rot    = elig_rot2[N_REQ-1:0];
        grant_valid = 1'b0;
        grant_off   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (elig_rot[k]) begin
                grant_valid = 1'b1;
                grant_off   = ID_W'(k);
            end
        end
        grant_sum = {1'b0, rr_ptr_q} + {1'b0, grant_off};
        if (grant_sum >= (ID_W+1)'(N_REQ)) begin
            grant_sum = grant_sum - (ID_W+1)'(N_REQ);
        end
        grant_idx = grant_sum[ID_W-1:0];
    end

    always_comb begin
        req_ready = '0;
        if (buf_ready && grant_valid) begin
            req_ready = N_REQ'(1) << grant_idx;
        end
    end

    assign push   = |(req_valid & req_ready);
    assign buf_in = {grant_idx, req_data[grant_idx]};

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = ID_W'(rr_next(32'(grant_idx), N_REQ));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    buffer #(
        .WIDTH (WIDTH + ID_W)
    ) u_buffer (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (out_pop),
        .in_data  (buf_in),
        .ready    (buf_ready),
        .valid    (out_valid),
        .out_data (buf_out)
    );

    assign out_data = buf_out[WIDTH-1:0];
    assign out_id   = buf_out[WIDTH+ID_W-1:WIDTH];

endmodule

// File: tb/tb_simd_buffer_arbiter.sv
// Self-checking bench: directed vector table, randomized run against a
// queue-free behavioural model, fairness sequence, and a 3-requester wrap check.
module tb_simd_buffer_arbiter;

    logic             clk;
    logic             rst;
    logic [3:0]       req_valid;
    logic [3:0][31:0] req_data;
    logic [3:0]       req_ready;
    logic [3:0]       cfg_mask;
    logic             out_valid;
    logic             out_pop;
    logic [31:0]      out_data;
    logic [1:0]       out_id;

    logic             rst3;
    logic [2:0]       req_valid3;
    logic [2:0][7:0]  req_data3;
    logic [2:0]       req_ready3;
    logic [2:0]       cfg_mask3;
    logic             out_valid3;
    logic             out_pop3;
    logic [7:0]       out_data3;
    logic [1:0]       out_id3;

    int n_checks;
    int n_fail;

    int          m_ptr;
    bit          m_full;
    logic [31:0] m_data;
    int          m_id;

    simd_buffer_arbiter #(.N_REQ(4), .WIDTH(32)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cfg_mask  (cfg_mask),
        .out_valid (out_valid),
        .out_pop   (out_pop),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    simd_buffer_arbiter #(.N_REQ(3), .WIDTH(8)) u_dut3 (
        .clk       (clk),
        .rst       (rst3),
        .req_valid (req_valid3),
        .req_data  (req_data3),
        .req_ready (req_ready3),
        .cfg_mask  (cfg_mask3),
        .out_valid (out_valid3),
        .out_pop   (out_pop3),
        .out_data  (out_data3),
        .out_id    (out_id3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic [3:0] mask;
        logic       pop;
        logic [3:0] exp_ready;
        logic       exp_valid;
        logic [1:0] exp_id;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected one-hot grant from the rules: first eligible index at or after
    // the pointer, modulo the requester count, only while the buffer is empty.
    function automatic logic [3:0] model_ready(input logic [3:0] v, input logic [3:0] m);
        if (m_full) return 4'b0;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr + k) % 4;
            if (v[i] && m[i]) return 4'b1 << i;
        end
        return 4'b0;
    endfunction

    task automatic apply_step(input logic r, input logic [3:0] v, input logic [3:0] m,
                              input logic p, output logic [3:0] s_ready,
                              output logic s_valid, output logic [1:0] s_id,
                              output logic [31:0] s_data);
        logic [3:0] exp_r;
        rst = r; req_valid = v; cfg_mask = m; out_pop = p;
        @(negedge clk);
        s_ready = req_ready; s_valid = out_valid; s_id = out_id; s_data = out_data;
        exp_r = model_ready(v, m);
        check("model_ready", {60'b0, req_ready}, {60'b0, exp_r});
        check("model_valid", {63'b0, out_valid}, {63'b0, m_full});
        if (m_full) begin
            check("model_id",   {62'b0, out_id}, 64'(m_id));
            check("model_data", {32'b0, out_data}, {32'b0, m_data});
        end
        @(posedge clk);
        if (r) begin
            m_full = 1'b0;
            m_ptr  = 0;
        end else if (m_full) begin
            if (p) m_full = 1'b0;
        end else if (exp_r != 4'b0) begin
            for (int i = 0; i < 4; i++) begin
                if (exp_r[i]) begin
                    m_full = 1'b1;
                    m_data = req_data[i];
                    m_id   = i;
                    m_ptr  = (i + 1) % 4;
                end
            end
        end
        #1;
    endtask

    initial begin
        vec_t        vecs[28];
        logic [3:0]  s_ready;
        logic        s_valid;
        logic [1:0]  s_id;
        logic [31:0] s_data;
        int          seen;

        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; req_valid = '0; cfg_mask = '0; out_pop = 1'b0;
        for (int i = 0; i < 4; i++) req_data[i] = 32'hA5A5_0000 + 32'(i);
        rst3 = 1'b1; req_valid3 = '0; cfg_mask3 = 3'b111; out_pop3 = 1'b0;
        for (int i = 0; i < 3; i++) req_data3[i] = 8'h30 + 8'(i);

        //           rst  valid    mask     pop   ready    ov    id
        vecs[0]  = '{1'b1, 4'hF, 4'hF, 1'b0, 4'b0001, 1'b0, 2'd0};
        vecs[1]  = '{1'b0, 4'hF, 4'hF, 1'b0, 4'b0001, 1'b0, 2'd0};
        vecs[2]  = '{1'b0, 4'h4, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd0};
        vecs[3]  = '{1'b0, 4'h4, 4'hF, 1'b1, 4'b0000, 1'b1, 2'd0};
        vecs[4]  = '{1'b0, 4'h4, 4'hF, 1'b0, 4'b0100, 1'b0, 2'd0};
        vecs[5]  = '{1'b0, 4'h4, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd2};
        vecs[6]  = '{1'b0, 4'h4, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd2};
        vecs[7]  = '{1'b0, 4'h4, 4'hF, 1'b1, 4'b0000, 1'b1, 2'd2};
        vecs[8]  = '{1'b0, 4'hF, 4'hF, 1'b0, 4'b1000, 1'b0, 2'd0};
        vecs[9]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'b0000, 1'b1, 2'd3};
        vecs[10] = '{1'b0, 4'hF, 4'hF, 1'b0, 4'b0001, 1'b0, 2'd0};
        vecs[11] = '{1'b0, 4'hF, 4'hF, 1'b1, 4'b0000, 1'b1, 2'd0};
        vecs[12] = '{1'b0, 4'hF, 4'hF, 1'b0, 4'b0010, 1'b0, 2'd0};
        vecs[13] = '{1'b0, 4'hF, 4'hF, 1'b1, 4'b0000, 1'b1, 2'd1};
        vecs[14] = '{1'b0, 4'hF, 4'hA, 1'b0, 4'b1000, 1'b0, 2'd0};
        vecs[15] = '{1'b0, 4'hF, 4'hA, 1'b1, 4'b0000, 1'b1, 2'd3};
        vecs[16] = '{1'b0, 4'hF, 4'hA, 1'b0, 4'b0010, 1'b0, 2'd0};
        vecs[17] = '{1'b0, 4'hF, 4'hA, 1'b1, 4'b0000, 1'b1, 2'd1};
        vecs[18] = '{1'b0, 4'hF, 4'h2, 1'b0, 4'b0010, 1'b0, 2'd0};
        vecs[19] = '{1'b0, 4'hF, 4'h2, 1'b1, 4'b0000, 1'b1, 2'd1};
        vecs[20] = '{1'b0, 4'hF, 4'h0, 1'b0, 4'b0000, 1'b0, 2'd0};
        vecs[21] = '{1'b0, 4'h0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0};
        vecs[22] = '{1'b0, 4'hF, 4'hF, 1'b0, 4'b0100, 1'b0, 2'd0};
        vecs[23] = '{1'b0, 4'hF, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd2};
        vecs[24] = '{1'b1, 4'hF, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd2};
        vecs[25] = '{1'b1, 4'hF, 4'hF, 1'b0, 4'b0001, 1'b0, 2'd0};
        vecs[26] = '{1'b0, 4'hF, 4'hF, 1'b0, 4'b0001, 1'b0, 2'd0};
        vecs[27] = '{1'b0, 4'hF, 4'hF, 1'b1, 4'b0000, 1'b1, 2'd0};

        @(posedge clk);
        #1;
        m_full = 1'b0; m_ptr = 0; m_data = '0; m_id = 0;

        for (int t = 0; t < 28; t++) begin
            apply_step(vecs[t].rst, vecs[t].valid, vecs[t].mask, vecs[t].pop,
                       s_ready, s_valid, s_id, s_data);
            check($sformatf("vec%0d_ready", t), {60'b0, s_ready}, {60'b0, vecs[t].exp_ready});
            check($sformatf("vec%0d_valid", t), {63'b0, s_valid}, {63'b0, vecs[t].exp_valid});
            if (vecs[t].exp_valid) begin
                check($sformatf("vec%0d_id", t), {62'b0, s_id}, {62'b0, vecs[t].exp_id});
                check($sformatf("vec%0d_data", t), {32'b0, s_data},
                      {32'b0, 32'hA5A5_0000 + {30'b0, vecs[t].exp_id}});
            end
        end

        for (int c = 0; c < 400; c++) begin
            logic       r;
            logic [3:0] m;
            for (int i = 0; i < 4; i++) req_data[i] = $urandom;
            r = ($urandom_range(0, 49) == 0);
            m = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            apply_step(r, 4'($urandom), m, 1'($urandom), s_ready, s_valid, s_id, s_data);
        end

        // Fairness: everyone eligible, consumer always popping.
        for (int i = 0; i < 4; i++) req_data[i] = 32'h5A5A_0000 + 32'(i);
        apply_step(1'b1, 4'hF, 4'hF, 1'b0, s_ready, s_valid, s_id, s_data);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            apply_step(1'b0, 4'hF, 4'hF, 1'b1, s_ready, s_valid, s_id, s_data);
            if (s_valid) begin
                check("fair_id", {62'b0, s_id}, 64'(seen % 4));
                seen++;
            end
        end
        check("fair_count", 64'(seen), 64'd10);

        // Three-requester instance: spurious pops, then wrap 2 -> 0.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst3 = 1'b0; out_pop3 = 1'b1; req_valid3 = 3'b000;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("n3_spur_valid", {63'b0, out_valid3}, 64'd0);
            check("n3_spur_ready", {61'b0, req_ready3}, 64'd0);
            @(posedge clk);
            #1;
        end
        req_valid3 = 3'b111;
        @(negedge clk);
        check("n3_first_ready", {61'b0, req_ready3}, 64'd1);
        seen = 0;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) @(negedge clk);
            if (out_valid3) begin
                check("n3_id",   {62'b0, out_id3}, 64'(seen % 3));
                check("n3_data", {56'b0, out_data3}, 64'(8'h30 + 8'(seen % 3)));
                seen++;
            end
            @(posedge clk);
            #1;
        end
        check("n3_count", 64'(seen), 64'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
